// File: rtl/des_key_schedule.sv
// des_key_schedule: DES subkey generator. Accepts a 64-bit key, then emits
// ROUNDS 48-bit subkeys one per SubKeyValid/SubKeyReady handshake, in K1..Kn
// order for encryption or K16 downward for decryption.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | KeyReady high, waiting for KeyValid
// RUN   | SubKeyValid high, C/D hold the subkey currently presented
module des_key_schedule #(
  parameter int ROUNDS     = 16,
  parameter bit DECRYPT_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [63:0] KeyIn,
  input  logic        Decrypt,
  input  logic        KeyValid,
  output logic        KeyReady,
  input  logic        Abort,
  output logic [47:0] SubKey,
  output logic [3:0]  Round,
  output logic        SubKeyValid,
  input  logic        SubKeyReady,
  output logic        Last
);

  typedef enum logic {IDLE, RUN} state_t;

  // FIPS 46-3 permuted choice tables, entries are 1-based bit numbers
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam logic [3:0] LAST_CNT = 4'(ROUNDS - 1);

  state_t      state_q;
  logic [27:0] c_q;
  logic [27:0] d_q;
  logic [3:0]  remain_q;
  logic [3:0]  round_q;
  logic        dec_q;
  logic        key_ready_q;
  logic        sub_key_valid_q;
  logic        last_q;

  logic [55:0] pc1_key;
  logic [55:0] cd;
  logic        mode_in;
  logic        step_one;
  logic        unused_parity;

  // bit 1 of the FIPS numbering sits at KeyIn[63]
  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1_key[55-i] = KeyIn[64-PC1_TAB[i]];
  end

  // pure wiring from the C/D registers to the subkey output
  assign cd = {c_q, d_q};
  for (genvar i = 0; i < 48; i++) begin : g_pc2
    assign SubKey[47-i] = cd[56-PC2_TAB[i]];
  end

  // parity bits 8,16,..,64 never enter PC1
  assign unused_parity = ^{KeyIn[56], KeyIn[48], KeyIn[40], KeyIn[32],
                           KeyIn[24], KeyIn[16], KeyIn[8],  KeyIn[0]};

  function automatic logic [27:0] rol(input logic [27:0] v, input logic one);
    return one ? {v[26:0], v[27]} : {v[25:0], v[27:26]};
  endfunction

  function automatic logic [27:0] ror(input logic [27:0] v, input logic one);
    return one ? {v[0], v[27:1]} : {v[1:0], v[27:2]};
  endfunction

  // r is a 0-based round index; rounds 1,2,9,16 shift by one
  function automatic logic single_shift(input logic [3:0] r);
    return (r == 4'd0) || (r == 4'd1) || (r == 4'd8) || (r == 4'd15);
  endfunction

  assign mode_in = DECRYPT_EN && Decrypt;

  // encrypt advances to the next round's shift; decrypt undoes the current one
  assign step_one = dec_q ? single_shift(round_q) : single_shift(round_q + 4'd1);

  // schedule FSM: key capture, per-handshake rotation, registered flags
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q         <= IDLE;
      c_q             <= '0;
      d_q             <= '0;
      remain_q        <= '0;
      round_q         <= '0;
      dec_q           <= 1'b0;
      key_ready_q     <= 1'b1;
      sub_key_valid_q <= 1'b0;
      last_q          <= 1'b0;
    end else if (Abort) begin
      state_q         <= IDLE;
      key_ready_q     <= 1'b1;
      sub_key_valid_q <= 1'b0;
      last_q          <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (KeyValid) begin
            // decrypt starts at K16, whose total rotation of 28 is the identity
            c_q             <= mode_in ? pc1_key[55:28] : rol(pc1_key[55:28], 1'b1);
            d_q             <= mode_in ? pc1_key[27:0]  : rol(pc1_key[27:0], 1'b1);
            dec_q           <= mode_in;
            remain_q        <= LAST_CNT;
            round_q         <= mode_in ? 4'd15 : 4'd0;
            state_q         <= RUN;
            key_ready_q     <= 1'b0;
            sub_key_valid_q <= 1'b1;
            last_q          <= (LAST_CNT == 4'd0);
          end
        end
        RUN: begin
          if (SubKeyReady) begin
            if (last_q) begin
              state_q         <= IDLE;
              key_ready_q     <= 1'b1;
              sub_key_valid_q <= 1'b0;
              last_q          <= 1'b0;
            end else begin
              c_q      <= dec_q ? ror(c_q, step_one) : rol(c_q, step_one);
              d_q      <= dec_q ? ror(d_q, step_one) : rol(d_q, step_one);
              round_q  <= dec_q ? round_q - 4'd1 : round_q + 4'd1;
              remain_q <= remain_q - 4'd1;
              last_q   <= (remain_q == 4'd1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign KeyReady    = key_ready_q;
  assign SubKeyValid = sub_key_valid_q;
  assign Last        = last_q;
  assign Round       = round_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic 133457799BBCDFF1 key.
module tb_des_key_schedule;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst;
  logic [63:0] key_in;
  logic        decrypt;
  logic        abort;
  logic        sk_ready;
  logic        kv, kv4, kv1;

  logic        kr, skv, last;
  logic [47:0] sk;
  logic [3:0]  rnd;
  logic        kr4, skv4, last4;
  logic [47:0] sk4;
  logic [3:0]  rnd4;
  logic        kr1, skv1, last1;
  logic [47:0] sk1;
  logic [3:0]  rnd1;

  int errors = 0;
  int checks = 0;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [47:0] EXP_K [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  des_key_schedule dut (
    .CLK(clk), .nRST(nrst), .KeyIn(key_in), .Decrypt(decrypt), .KeyValid(kv),
    .KeyReady(kr), .Abort(abort), .SubKey(sk), .Round(rnd), .SubKeyValid(skv),
    .SubKeyReady(sk_ready), .Last(last)
  );

  des_key_schedule #(.ROUNDS(4), .DECRYPT_EN(1'b0)) dut4 (
    .CLK(clk), .nRST(nrst), .KeyIn(key_in), .Decrypt(decrypt), .KeyValid(kv4),
    .KeyReady(kr4), .Abort(abort), .SubKey(sk4), .Round(rnd4), .SubKeyValid(skv4),
    .SubKeyReady(sk_ready), .Last(last4)
  );

  des_key_schedule #(.ROUNDS(1)) dut1 (
    .CLK(clk), .nRST(nrst), .KeyIn(key_in), .Decrypt(decrypt), .KeyValid(kv1),
    .KeyReady(kr1), .Abort(abort), .SubKey(sk1), .Round(rnd1), .SubKeyValid(skv1),
    .SubKeyReady(sk_ready), .Last(last1)
  );

  task automatic test_reset;
    nrst = 1'b0; key_in = '0; decrypt = 1'b0; abort = 1'b0; sk_ready = 1'b0;
    kv = 1'b0; kv4 = 1'b0; kv1 = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (kr !== 1'b1) begin errors++; $display("FAIL reset_keyready got %b want 1", kr); end
    checks++; if (skv !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", skv); end
    checks++; if (last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", last); end
    checks++; if (sk !== 48'h0) begin errors++; $display("FAIL reset_subkey got %h want 0", sk); end
    checks++; if (rnd !== 4'd0) begin errors++; $display("FAIL reset_round got %0d want 0", rnd); end
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_encrypt;
    @(negedge clk); key_in = KEY; decrypt = 1'b0; sk_ready = 1'b1; kv = 1'b1;
    @(negedge clk); kv = 1'b0;
    for (int j = 0; j < 16; j++) begin
      checks++; if (skv !== 1'b1) begin errors++; $display("FAIL enc_valid step %0d got %b want 1", j+1, skv); end
      checks++; if (sk !== EXP_K[j]) begin errors++; $display("FAIL enc_subkey step %0d got %h want %h", j+1, sk, EXP_K[j]); end
      checks++; if (rnd !== 4'(j)) begin errors++; $display("FAIL enc_round step %0d got %0d want %0d", j+1, rnd, j); end
      checks++; if (last !== (j == 15)) begin errors++; $display("FAIL enc_last step %0d got %b want %b", j+1, last, (j == 15)); end
      checks++; if (kr !== 1'b0) begin errors++; $display("FAIL enc_keyready step %0d got %b want 0", j+1, kr); end
      @(negedge clk);
    end
    checks++; if (kr !== 1'b1) begin errors++; $display("FAIL enc_end_keyready got %b want 1", kr); end
    checks++; if (skv !== 1'b0) begin errors++; $display("FAIL enc_end_valid got %b want 0", skv); end
  endtask

  task automatic test_decrypt;
    @(negedge clk); key_in = KEY; decrypt = 1'b1; sk_ready = 1'b1; kv = 1'b1;
    @(negedge clk); kv = 1'b0; decrypt = 1'b0;
    for (int j = 0; j < 16; j++) begin
      checks++; if (skv !== 1'b1) begin errors++; $display("FAIL dec_valid step %0d got %b want 1", j+1, skv); end
      checks++; if (sk !== EXP_K[15-j]) begin errors++; $display("FAIL dec_subkey step %0d got %h want %h", j+1, sk, EXP_K[15-j]); end
      checks++; if (rnd !== 4'(15-j)) begin errors++; $display("FAIL dec_round step %0d got %0d want %0d", j+1, rnd, 15-j); end
      checks++; if (last !== (j == 15)) begin errors++; $display("FAIL dec_last step %0d got %b want %b", j+1, last, (j == 15)); end
      @(negedge clk);
    end
    checks++; if (kr !== 1'b1) begin errors++; $display("FAIL dec_end_keyready got %b want 1", kr); end
    checks++; if (skv !== 1'b0) begin errors++; $display("FAIL dec_end_valid got %b want 0", skv); end
  endtask

  task automatic test_stall;
    int  j;
    bit  done;
    logic rdy;
    j = 0; done = 1'b0;
    @(negedge clk); key_in = KEY; decrypt = 1'b0; sk_ready = 1'b0; kv = 1'b1;
    // keep offering a different key during the run; it must be ignored
    @(negedge clk); key_in = 64'hFFFF_0000_A5A5_5A5A;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      checks++; if (skv !== 1'b1) begin errors++; $display("FAIL stall_valid step %0d got %b want 1", j+1, skv); end
      checks++; if (sk !== EXP_K[j]) begin errors++; $display("FAIL stall_subkey step %0d got %h want %h", j+1, sk, EXP_K[j]); end
      checks++; if (rnd !== 4'(j)) begin errors++; $display("FAIL stall_round step %0d got %0d want %0d", j+1, rnd, j); end
      checks++; if (last !== (j == 15)) begin errors++; $display("FAIL stall_last step %0d got %b want %b", j+1, last, (j == 15)); end
      checks++; if (kr !== 1'b0) begin errors++; $display("FAIL stall_keyready step %0d got %b want 0", j+1, kr); end
      rdy = (cyc < 3) ? 1'b0 : 1'($urandom_range(0, 1));
      sk_ready = rdy;
      kv = (j < 15);
      if (rdy) begin
        if (j == 15) done = 1'b1;
        else j++;
      end
      @(negedge clk);
    end
    kv = 1'b0;
    checks++; if (!done) begin errors++; $display("FAIL stall_timeout reached step %0d want 16", j+1); end
    checks++; if (kr !== 1'b1) begin errors++; $display("FAIL stall_end_keyready got %b want 1", kr); end
    checks++; if (skv !== 1'b0) begin errors++; $display("FAIL stall_end_valid got %b want 0", skv); end
    sk_ready = 1'b1;
  endtask

  task automatic test_abort;
    @(negedge clk); key_in = KEY; decrypt = 1'b0; sk_ready = 1'b1; kv = 1'b1;
    @(negedge clk); kv = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (rnd !== 4'd4) begin errors++; $display("FAIL abort_at_step5 round got %0d want 4", rnd); end
    abort = 1'b1;
    @(negedge clk);
    checks++; if (skv !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", skv); end
    checks++; if (kr !== 1'b1) begin errors++; $display("FAIL abort_keyready got %b want 1", kr); end
    kv = 1'b1;
    @(negedge clk);
    checks++; if (skv !== 1'b0) begin errors++; $display("FAIL abort_blocks_accept valid got %b want 0", skv); end
    abort = 1'b0;
    @(negedge clk); kv = 1'b0;
    checks++; if (skv !== 1'b1) begin errors++; $display("FAIL abort_restart_valid got %b want 1", skv); end
    checks++; if (rnd !== 4'd0) begin errors++; $display("FAIL abort_restart_round got %0d want 0", rnd); end
    checks++; if (sk !== EXP_K[0]) begin errors++; $display("FAIL abort_restart_subkey got %h want %h", sk, EXP_K[0]); end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++; if (kr !== 1'b1) begin errors++; $display("FAIL abort_cleanup_keyready got %b want 1", kr); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk); key_in = KEY; decrypt = 1'b0; sk_ready = 1'b1; kv = 1'b1;
    @(negedge clk); kv = 1'b0;
    repeat (7) @(negedge clk);
    checks++; if (rnd !== 4'd7) begin errors++; $display("FAIL rstmid_at_step8 round got %0d want 7", rnd); end
    nrst = 1'b0;
    #1;
    checks++; if (skv !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", skv); end
    checks++; if (sk !== 48'h0) begin errors++; $display("FAIL rstmid_subkey got %h want 0", sk); end
    checks++; if (kr !== 1'b1) begin errors++; $display("FAIL rstmid_keyready got %b want 1", kr); end
    @(negedge clk); nrst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (skv !== 1'b0) begin errors++; $display("FAIL rstmid_stays_idle valid got %b want 0", skv); end
  endtask

  task automatic test_rounds4;
    // Decrypt is driven high but this instance has DECRYPT_EN = 0
    @(negedge clk); key_in = KEY; decrypt = 1'b1; sk_ready = 1'b1; kv4 = 1'b1;
    @(negedge clk); kv4 = 1'b0; decrypt = 1'b0;
    for (int j = 0; j < 4; j++) begin
      checks++; if (skv4 !== 1'b1) begin errors++; $display("FAIL r4_valid step %0d got %b want 1", j+1, skv4); end
      checks++; if (sk4 !== EXP_K[j]) begin errors++; $display("FAIL r4_subkey step %0d got %h want %h", j+1, sk4, EXP_K[j]); end
      checks++; if (rnd4 !== 4'(j)) begin errors++; $display("FAIL r4_round step %0d got %0d want %0d", j+1, rnd4, j); end
      checks++; if (last4 !== (j == 3)) begin errors++; $display("FAIL r4_last step %0d got %b want %b", j+1, last4, (j == 3)); end
      @(negedge clk);
    end
    checks++; if (kr4 !== 1'b1) begin errors++; $display("FAIL r4_end_keyready got %b want 1", kr4); end
    checks++; if (skv4 !== 1'b0) begin errors++; $display("FAIL r4_end_valid got %b want 0", skv4); end
  endtask

  task automatic test_rounds1;
    @(negedge clk); key_in = KEY; decrypt = 1'b0; sk_ready = 1'b1; kv1 = 1'b1;
    @(negedge clk); kv1 = 1'b0;
    checks++; if (sk1 !== EXP_K[0]) begin errors++; $display("FAIL r1_enc_subkey got %h want %h", sk1, EXP_K[0]); end
    checks++; if (rnd1 !== 4'd0) begin errors++; $display("FAIL r1_enc_round got %0d want 0", rnd1); end
    checks++; if (last1 !== 1'b1) begin errors++; $display("FAIL r1_enc_last got %b want 1", last1); end
    checks++; if (skv1 !== 1'b1) begin errors++; $display("FAIL r1_enc_valid got %b want 1", skv1); end
    @(negedge clk);
    checks++; if (skv1 !== 1'b0) begin errors++; $display("FAIL r1_enc_end_valid got %b want 0", skv1); end
    checks++; if (kr1 !== 1'b1) begin errors++; $display("FAIL r1_enc_end_keyready got %b want 1", kr1); end
    decrypt = 1'b1; kv1 = 1'b1;
    @(negedge clk); kv1 = 1'b0; decrypt = 1'b0;
    checks++; if (sk1 !== EXP_K[15]) begin errors++; $display("FAIL r1_dec_subkey got %h want %h", sk1, EXP_K[15]); end
    checks++; if (rnd1 !== 4'd15) begin errors++; $display("FAIL r1_dec_round got %0d want 15", rnd1); end
    checks++; if (last1 !== 1'b1) begin errors++; $display("FAIL r1_dec_last got %b want 1", last1); end
    @(negedge clk);
    checks++; if (skv1 !== 1'b0) begin errors++; $display("FAIL r1_dec_end_valid got %b want 0", skv1); end
  endtask

  initial begin
    test_reset;
    test_encrypt;
    test_decrypt;
    test_stall;
    test_abort;
    test_reset_mid;
    test_rounds4;
    test_rounds1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
